// File: rtl/button_ctrl_pkg.sv
// Shared mode encoding, default timing and the mode-advance helper for the
// three-key button controller.
package button_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SET       = 2'd1,
    MODE_STOPWATCH = 2'd2
  } mode_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_HOLD_CYCLES     = 25000000;
  localparam int DEFAULT_REPEAT_CYCLES   = 10000000;

  // The encoding 3 is unreachable; if it ever appears we recover to clock mode.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_CLOCK: return MODE_SET;
      MODE_SET:   return MODE_STOPWATCH;
      default:    return MODE_CLOCK;
    endcase
  endfunction

endpackage

// File: rtl/button_ctrl_debounce.sv
// One key: two-flop synchronizer, stable-sample debounce counter and a
// single-cycle pulse on each accepted press.
module button_ctrl_debounce
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;
  logic          pressed_now;

  assign pressed_now = ~sync2;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample;
  // a single agreeing sample restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      count <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (pressed_now == level) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        count <= '0;
        level <= pressed_now;
        press <= pressed_now;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_ctrl.sv
// Mode key cycles clock/set/stopwatch; keys A and B are routed to stopwatch
// or adjust pulses by the current mode, with auto-repeat on A while adjusting.
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode_n,
  input  logic       btn_a_n,
  input  logic       btn_b_n,
  output logic [1:0] rezhim,
  output logic       button_start_stop,
  output logic       button_reset,
  output logic       adjust_inc,
  output logic       adjust_next
);

  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW      = $clog2(RPT_MAX + 1);

  mode_t         mode;
  logic          mode_press;
  logic          a_press;
  logic          a_level;
  logic          b_press;
  logic          mode_level_unused;
  logic          b_level_unused;
  logic          adjust_ok;
  logic          rpt_active;
  logic          rpt_repeat;
  logic [RW-1:0] rpt_count;
  logic [RW-1:0] rpt_limit;
  logic          rpt_fire;

  button_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
    .clock (clock),
    .reset (reset),
    .key_n (btn_mode_n),
    .level (mode_level_unused),
    .press (mode_press)
  );

  button_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a_key (
    .clock (clock),
    .reset (reset),
    .key_n (btn_a_n),
    .level (a_level),
    .press (a_press)
  );

  button_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b_key (
    .clock (clock),
    .reset (reset),
    .key_n (btn_b_n),
    .level (b_level_unused),
    .press (b_press)
  );

  assign rezhim    = mode;
  assign adjust_ok = (mode != MODE_STOPWATCH);
  assign rpt_limit = rpt_repeat ? RW'(REPEAT_CYCLES) : RW'(HOLD_CYCLES);
  assign rpt_fire  = rpt_active && a_level && !mode_press && adjust_ok &&
                     (rpt_count == rpt_limit);

  // Routing uses the mode before this cycle's update; a mode press or a
  // debounced release kills the repeat, and only a fresh A press restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode              <= MODE_CLOCK;
      button_start_stop <= 1'b0;
      button_reset      <= 1'b0;
      adjust_inc        <= 1'b0;
      adjust_next       <= 1'b0;
      rpt_active        <= 1'b0;
      rpt_repeat        <= 1'b0;
      rpt_count         <= '0;
    end else begin
      button_start_stop <= a_press && !adjust_ok;
      button_reset      <= b_press && !adjust_ok;
      adjust_inc        <= (a_press && adjust_ok) || rpt_fire;
      adjust_next       <= b_press && adjust_ok;

      if (mode_press) begin
        mode <= next_mode(mode);
      end

      if (mode_press || !a_level) begin
        rpt_active <= 1'b0;
        rpt_repeat <= 1'b0;
        rpt_count  <= '0;
      end else if (a_press && adjust_ok) begin
        rpt_active <= 1'b1;
        rpt_repeat <= 1'b0;
        rpt_count  <= RW'(1);
      end else if (rpt_active) begin
        if (rpt_fire) begin
          rpt_repeat <= 1'b1;
          rpt_count  <= RW'(1);
        end else if (rpt_count != '1) begin
          rpt_count <= rpt_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with short timing: a vector table of single
// presses plus hand-written sequences for repeat, bounce and reset corners.
module tb_button_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_mode_n;
  logic       btn_a_n;
  logic       btn_b_n;
  logic [1:0] rezhim;
  logic       button_start_stop;
  logic       button_reset;
  logic       adjust_inc;
  logic       adjust_next;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] cur_mode;

  // Keys are packed {mode_n, a_n, b_n}; pulses are packed {start_stop, reset, inc, next}.
  typedef struct {
    logic [2:0] keys_n;
    int         hold;
    logic [1:0] exp_mode;
    logic [3:0] exp_pulses;
    string      name;
  } vec_t;

  vec_t table_v[12];

  button_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .btn_mode_n        (btn_mode_n),
    .btn_a_n           (btn_a_n),
    .btn_b_n           (btn_b_n),
    .rezhim            (rezhim),
    .button_start_stop (button_start_stop),
    .button_reset      (button_reset),
    .adjust_inc        (adjust_inc),
    .adjust_next       (adjust_next)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_keys(input logic [2:0] k);
    {btn_mode_n, btn_a_n, btn_b_n} = k;
  endtask

  function automatic logic [3:0] cur_pulses();
    return {button_start_stop, button_reset, adjust_inc, adjust_next};
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic set_vec(input int i, input logic [2:0] k, input int hold,
                         input logic [1:0] m, input logic [3:0] p, input string name);
    table_v[i].keys_n     = k;
    table_v[i].hold       = hold;
    table_v[i].exp_mode   = m;
    table_v[i].exp_pulses = p;
    table_v[i].name       = name;
  endtask

  // Press the keys from edge N; nothing before N+7, the expected result at
  // N+7, silence at N+8 and through the debounced release.
  task automatic applyStimulus(input vec_t v);
    logic [3:0] seen;
    drive_keys(v.keys_n);
    for (int k = 1; k <= v.hold; k++) begin
      tick();
      if (k == 6) begin
        checkOutput({v.name, " pulses early"}, cur_pulses(), 4'b0000);
        checkOutput({v.name, " mode early"}, {2'b00, rezhim}, {2'b00, cur_mode});
      end
      if (k == 7) begin
        checkOutput({v.name, " pulses"}, cur_pulses(), v.exp_pulses);
        checkOutput({v.name, " mode"}, {2'b00, rezhim}, {2'b00, v.exp_mode});
      end
      if (k == 8) checkOutput({v.name, " pulses after"}, cur_pulses(), 4'b0000);
    end
    drive_keys(3'b111);
    seen = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      seen |= cur_pulses();
    end
    checkOutput({v.name, " release quiet"}, seen, 4'b0000);
    cur_mode = v.exp_mode;
  endtask

  initial begin
    logic [63:0] mask;

    set_vec(0,  3'b011, 20, 2'd1, 4'b0000, "mode clock->set");
    set_vec(1,  3'b011, 20, 2'd2, 4'b0000, "mode set->stopwatch");
    set_vec(2,  3'b011, 20, 2'd0, 4'b0000, "mode stopwatch->clock");
    set_vec(3,  3'b101, 8,  2'd0, 4'b0010, "A in clock");
    set_vec(4,  3'b110, 8,  2'd0, 4'b0001, "B in clock");
    set_vec(5,  3'b011, 20, 2'd1, 4'b0000, "mode to set");
    set_vec(6,  3'b100, 8,  2'd1, 4'b0011, "A+B in set");
    set_vec(7,  3'b010, 8,  2'd2, 4'b0001, "mode+B in set");
    set_vec(8,  3'b101, 8,  2'd2, 4'b1000, "A in stopwatch");
    set_vec(9,  3'b110, 8,  2'd2, 4'b0100, "B in stopwatch");
    set_vec(10, 3'b100, 8,  2'd2, 4'b1100, "A+B in stopwatch");
    set_vec(11, 3'b001, 8,  2'd0, 4'b1000, "mode+A in stopwatch");

    drive_keys(3'b111);
    reset = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("reset pulses", cur_pulses(), 4'b0000);
    checkOutput("reset mode", {2'b00, rezhim}, 4'b0000);
    reset = 1'b0;
    cur_mode = 2'd0;

    for (int i = 0; i < 12; i++) applyStimulus(table_v[i]);

    // Long A hold in clock mode: press at +7, first repeat 10 later, then every 3.
    mask = '0;
    mask[7] = 1'b1; mask[17] = 1'b1; mask[20] = 1'b1; mask[23] = 1'b1;
    mask[26] = 1'b1; mask[29] = 1'b1; mask[32] = 1'b1; mask[35] = 1'b1;
    drive_keys(3'b101);
    for (int k = 1; k <= 45; k++) begin
      tick();
      checkOutput($sformatf("repeat inc k=%0d", k), {3'b000, adjust_inc}, {3'b000, mask[k]});
      if (k == 30) drive_keys(3'b111);
    end
    for (int k = 0; k < 5; k++) tick();

    // Mode press during repeat: mode changes at +25, repeats stop and do not resume in set.
    mask = '0;
    mask[7] = 1'b1; mask[17] = 1'b1; mask[20] = 1'b1; mask[23] = 1'b1;
    drive_keys(3'b101);
    for (int k = 1; k <= 40; k++) begin
      tick();
      checkOutput($sformatf("mode stops repeat k=%0d", k), {3'b000, adjust_inc}, {3'b000, mask[k]});
      if (k == 18) drive_keys(3'b001);
    end
    checkOutput("mode after repeat stop", {2'b00, rezhim}, 4'b0001);
    drive_keys(3'b111);
    for (int k = 0; k < 15; k++) tick();
    cur_mode = 2'd1;

    // Bouncing A in stopwatch: single start_stop 7 cycles after the final edge (k=12).
    applyStimulus(table_v[1]);
    drive_keys(3'b101);
    for (int k = 1; k <= 32; k++) begin
      tick();
      checkOutput($sformatf("bounce k=%0d", k), {2'b00, button_start_stop, adjust_inc},
                  {2'b00, (k == 19), 1'b0});
      if (k <= 12 && (k % 4) == 2) drive_keys(3'b111);
      if (k <= 12 && (k % 4) == 0) drive_keys(3'b101);
    end
    drive_keys(3'b111);
    for (int k = 0; k < 12; k++) tick();

    // Reset two cycles into an A press from set mode: restart and one inc 7 after reset release.
    applyStimulus(table_v[2]);
    applyStimulus(table_v[0]);
    drive_keys(3'b101);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("reset mid-debounce pulses", cur_pulses(), 4'b0000);
    checkOutput("reset mid-debounce mode", {2'b00, rezhim}, 4'b0000);
    for (int k = 1; k <= 14; k++) begin
      tick();
      checkOutput($sformatf("post-reset k=%0d", k), cur_pulses(), {2'b00, (k == 7), 1'b0});
    end
    drive_keys(3'b111);
    for (int k = 0; k < 12; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
